// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: independent TX and RX FSMs on one clock with a fixed baud divider.
// Define UART_PARITY_EN to insert/check an even-parity bit after D7 (11-bit frames).
module uart_core #(
    parameter int INPUT_FREQ = 5_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] rx_data,
    output logic       received_data_intr,
    input  logic [7:0] tx_data,
    input  logic       send_data,
    output logic       busy
);
    localparam int CLKS_PER_BIT = (INPUT_FREQ + BAUD_RATE/2) / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PAR,
`endif
        S_STOP
    } state_t;

    // ---------------- transmitter ----------------
    state_t        tx_st_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_sh_q;
    logic          txd_q, busy_q;
`ifdef UART_PARITY_EN
    logic          tx_par_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_st_q  <= S_IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q <= 1'b0;
`endif
        end else if (tx_st_q == S_IDLE) begin
            if (send_data) begin
                tx_sh_q  <= tx_data;
                tx_st_q  <= S_START;
                tx_cnt_q <= '0;
                txd_q    <= 1'b0;
                busy_q   <= 1'b1;
`ifdef UART_PARITY_EN
                tx_par_q <= ^tx_data;
`endif
            end
        end else if (tx_cnt_q != BIT_LAST) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
        end else begin
            tx_cnt_q <= '0;
            case (tx_st_q)
                S_START: begin
                    tx_st_q  <= S_DATA;
                    tx_bit_q <= '0;
                    txd_q    <= tx_sh_q[0];
                end
                S_DATA: begin
                    tx_sh_q  <= tx_sh_q >> 1;
                    tx_bit_q <= tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_st_q <= S_PAR;
                        txd_q   <= tx_par_q;
`else
                        tx_st_q <= S_STOP;
                        txd_q   <= 1'b1;
`endif
                    end else begin
                        txd_q <= tx_sh_q[1];
                    end
                end
`ifdef UART_PARITY_EN
                S_PAR: begin
                    tx_st_q <= S_STOP;
                    txd_q   <= 1'b1;
                end
`endif
                default: begin
                    // End of stop bit: a pending request starts the next frame with no idle gap.
                    if (send_data) begin
                        tx_sh_q <= tx_data;
                        tx_st_q <= S_START;
                        txd_q   <= 1'b0;
`ifdef UART_PARITY_EN
                        tx_par_q <= ^tx_data;
`endif
                    end else begin
                        tx_st_q <= S_IDLE;
                        txd_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

    // ---------------- receiver ----------------
    logic          rx_s1_q, rx_s2_q;
    state_t        rx_st_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q, rx_data_q;
    logic          rx_intr_q, rx_err_q;
`ifdef UART_PARITY_EN
    logic          rx_par_ok_q;
`endif

    // Synchronizer resets high so release never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rxd;
            rx_s2_q <= rx_s1_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            rx_intr_q <= 1'b0;
            rx_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_ok_q <= 1'b0;
`endif
        end else begin
            rx_intr_q <= 1'b0;
            case (rx_st_q)
                S_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_err_q) begin
                        if (rx_s2_q) rx_err_q <= 1'b0;
                    end else if (!rx_s2_q) begin
                        rx_st_q <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_st_q  <= rx_s2_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt_q != BIT_LAST) begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end else begin
                        rx_cnt_q <= '0;
                        case (rx_st_q)
                            S_DATA: begin
                                rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                                rx_bit_q <= rx_bit_q + 3'd1;
`ifdef UART_PARITY_EN
                                if (rx_bit_q == 3'd7) rx_st_q <= S_PAR;
`else
                                if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
`endif
                            end
`ifdef UART_PARITY_EN
                            S_PAR: begin
                                rx_par_ok_q <= (rx_s2_q == ^rx_sh_q);
                                rx_st_q     <= S_STOP;
                            end
`endif
                            default: begin
                                rx_st_q <= S_IDLE;
`ifdef UART_PARITY_EN
                                if (rx_s2_q && rx_par_ok_q) begin
`else
                                if (rx_s2_q) begin
`endif
                                    rx_data_q <= rx_sh_q;
                                    rx_intr_q <= 1'b1;
                                end else begin
                                    rx_err_q <= !rx_s2_q;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign rx_data            = rx_data_q;
    assign received_data_intr = rx_intr_q;
endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core (default 8N1 build): vector table for RX corner cases,
// randomized RX/loopback traffic against a frame-level model, hand sequences for TX corners.
module tb_uart_core;
    localparam int CPB = 43;

    logic       clk = 1'b0;
    logic       reset, rxd, txd, received_data_intr, send_data, busy;
    logic [7:0] rx_data, tx_data;
    logic       loop, rxd_drv;

    assign rxd = loop ? txd : rxd_drv;
    always #5 clk = ~clk;

    uart_core dut (
        .clk(clk), .reset(reset), .rxd(rxd), .txd(txd), .rx_data(rx_data),
        .received_data_intr(received_data_intr), .tx_data(tx_data),
        .send_data(send_data), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] rxq[$];

    always @(negedge clk) if (received_data_intr) rxq.push_back(rx_data);

    typedef struct {
        int         glitch;
        logic [7:0] data;
        logic       stp;
        logic       exp_pulse;
        logic [7:0] exp_data;
    } rx_vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int i);
        if (i < rxq.size()) return rxq[i];
        return 8'hxx;
    endfunction

    // Drive one external RX event: a short low glitch, or a full frame with chosen stop bit.
    task automatic rx_drive(input rx_vec_t v, input string nm);
        logic [9:0] fr;
        int c0;
        fr = {v.stp, v.data, 1'b0};
        c0 = rxq.size();
        if (v.glitch > 0) begin
            rxd_drv = 1'b0;
            repeat (v.glitch) @(negedge clk);
        end else begin
            for (int k = 0; k < 10; k++) begin
                rxd_drv = fr[k];
                repeat (CPB) @(negedge clk);
            end
        end
        rxd_drv = 1'b1;
        repeat (120) @(negedge clk);
        check({nm, "_pulses"}, rxq.size() - c0, {31'd0, v.exp_pulse});
        check({nm, "_rx_data"}, rx_data, v.exp_data);
    endtask

    // Loopback transmit of one frame (or two back-to-back), optional ignored request at cycle inj.
    task automatic tx_run(input logic [7:0] b0, input logic [7:0] b1, input int nfr,
                          input int inj, input string nm);
        logic [19:0] fr, got, mask;
        int n, c0;
        fr   = {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
        mask = (nfr == 2) ? 20'hFFFFF : 20'h003FF;
        got  = '0;
        n    = 0;
        c0   = rxq.size();
        @(negedge clk);
        tx_data   = b0;
        send_data = 1'b1;
        @(negedge clk);
        if (nfr == 1) send_data = 1'b0;
        else          tx_data   = b1;
        while (busy && n < 2000) begin
            if (n % CPB == CPB/2 && n / CPB < 20) got[n / CPB] = txd;
            if (nfr == 2 && n == 10*CPB) send_data = 1'b0;
            if (inj >= 0 && n == inj)     begin tx_data = 8'h3C; send_data = 1'b1; end
            if (inj >= 0 && n == inj + 1) send_data = 1'b0;
            n++;
            @(negedge clk);
        end
        send_data = 1'b0;
        check({nm, "_busy_len"}, n, 10*CPB*nfr);
        check({nm, "_rx_before_busy_fall"}, rxq.size() - c0, nfr);
        check({nm, "_txd_bits"}, got & mask, fr & mask);
        check({nm, "_rx_byte0"}, q_at(c0), b0);
        if (nfr == 2) check({nm, "_rx_byte1"}, q_at(c0 + 1), b1);
        repeat (100) @(negedge clk);
        check({nm, "_idle_after"}, {txd, busy}, 2'b10);
        check({nm, "_rx_data"}, rx_data, (nfr == 2) ? b1 : b0);
    endtask

    initial begin
        rx_vec_t    tbl[6];
        rx_vec_t    v;
        logic [7:0] last_good;
        int         c0;

        tbl[0] = '{10, 8'h00, 1'b1, 1'b0, 8'h00};  // glitch shorter than half a bit
        tbl[1] = '{0,  8'h77, 1'b0, 1'b0, 8'h00};  // framing error
        tbl[2] = '{0,  8'h5A, 1'b1, 1'b1, 8'h5A};
        tbl[3] = '{10, 8'h00, 1'b1, 1'b0, 8'h5A};
        tbl[4] = '{0,  8'h81, 1'b0, 1'b0, 8'h5A};
        tbl[5] = '{0,  8'h81, 1'b1, 1'b1, 8'h81};

        reset = 1'b0; rxd_drv = 1'b1; loop = 1'b0; send_data = 1'b0; tx_data = 8'h00;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_intr", received_data_intr, 1'b0);

        for (int i = 0; i < 6; i++) rx_drive(tbl[i], $sformatf("rxvec%0d", i));

        last_good = tbl[5].exp_data;
        for (int i = 0; i < 8; i++) begin
            v.glitch = 0;
            v.data   = 8'($urandom);
            v.stp    = ($urandom_range(0, 3) != 0);
            v.exp_pulse = v.stp;
            v.exp_data  = v.stp ? v.data : last_good;
            rx_drive(v, $sformatf("rxrand%0d", i));
            if (v.stp) last_good = v.data;
        end

        loop = 1'b1;
        repeat (5) @(negedge clk);
        tx_run(8'hA5, 8'h00, 1, -1, "lb_A5");
        tx_run(8'h00, 8'hFF, 2, -1, "b2b");
        tx_run(8'h69, 8'h00, 1, 200, "ignore_3C");
        for (int i = 0; i < 5; i++) tx_run(8'($urandom), 8'h00, 1, -1, $sformatf("lbrand%0d", i));

        // Reset in the middle of data bit 4 of a loopback frame.
        @(negedge clk);
        tx_data = 8'h96; send_data = 1'b1;
        @(negedge clk);
        send_data = 1'b0;
        repeat (5*CPB + CPB/2) @(negedge clk);
        c0 = rxq.size();
        reset = 1'b0;
        #1;
        check("midrst_txd", txd, 1'b1);
        check("midrst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (600) @(negedge clk);
        check("midrst_no_intr", rxq.size() - c0, 0);
        check("midrst_rx_data", rx_data, 8'h00);
        tx_run(8'hC3, 8'h00, 1, -1, "after_rst_C3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
